// File: rtl/rv_commit_checker.sv
// Commit-trace checker: compares each retired instruction against a loaded table of expected
// retire records. Define RV_CHK_WATCHDOG_EN to add the no-commit watchdog.
module rv_commit_checker #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned IDX_W       = $clog2(DEPTH),
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned TIMEOUT     = 256,
    parameter int unsigned STOP_ON_ERR = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                exp_wr_en,
    input  logic [IDX_W-1:0]    exp_wr_addr,
    input  logic [2*XLEN+5:0]   exp_wr_data,
    input  logic [IDX_W:0]      num_entries,
    input  logic                start,
    input  logic                commit_valid,
    input  logic [XLEN-1:0]     commit_pc,
    input  logic                commit_we,
    input  logic [4:0]          commit_rd,
    input  logic [XLEN-1:0]     commit_wdata,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [IDX_W-1:0]    first_err_idx,
    output logic [3:0]          first_err_mask,
    output logic [IDX_W:0]      entry_idx,
    output logic                overrun,
    output logic                timeout
);

    localparam int unsigned EW = 2 * XLEN + 6;

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StDone = 2'b10;

    logic [EW-1:0]    table_mem [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   num_q, num_d;
    logic [IDX_W:0]   entry_q, entry_d, entry_inc;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] ferr_idx_q, ferr_idx_d;
    logic [3:0]       ferr_mask_q, ferr_mask_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic [EW-1:0]    exp_entry;
    logic [XLEN-1:0]  exp_pc, exp_wdata;
    logic             exp_we;
    logic [4:0]       exp_rd;
    logic             commit_we_n;
    logic [3:0]       mis_mask;
    logic             start_ok;
    logic             wd_expire;

    assign exp_entry = table_mem[entry_q[IDX_W-1:0]];
    assign exp_pc    = exp_entry[EW-1 -: XLEN];
    assign exp_we    = exp_entry[XLEN+5];
    assign exp_rd    = exp_entry[XLEN+4:XLEN];
    assign exp_wdata = exp_entry[XLEN-1:0];

    // A write to x0 has no architectural effect, so it is compared as we=0.
    assign commit_we_n = commit_we && (commit_rd != 5'd0);
    assign mis_mask    = {commit_pc != exp_pc,
                          commit_we_n != exp_we,
                          exp_we && (commit_rd != exp_rd),
                          exp_we && (commit_wdata != exp_wdata)};

    assign start_ok  = start && (state_q != StRun);
    assign entry_inc = entry_q + (IDX_W + 1)'(1);

    // The table is not reset; loads are blocked while a trace is being checked.
    always_ff @(posedge CLK) begin
        if (exp_wr_en && (state_q != StRun)) begin
            table_mem[exp_wr_addr] <= exp_wr_data;
        end
    end

`ifdef RV_CHK_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_q <= '0;
        end else if (start_ok || commit_valid) begin
            wd_q <= '0;
        end else if (state_q == StRun) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign wd_expire = (state_q == StRun) && !commit_valid && (wd_q == WD_W'(TIMEOUT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        entry_d     = entry_q;
        err_d       = err_q;
        ferr_idx_d  = ferr_idx_q;
        ferr_mask_d = ferr_mask_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;

        case (state_q)
            StIdle, StDone: begin
                // start takes priority over a commit arriving in the same cycle
                if (start) begin
                    num_d       = num_entries;
                    entry_d     = '0;
                    err_d       = '0;
                    ferr_idx_d  = '0;
                    ferr_mask_d = '0;
                    overrun_d   = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = (num_entries == '0) ? StDone : StRun;
                end else if ((state_q == StDone) && commit_valid) begin
                    overrun_d = 1'b1;
                end
            end
            StRun: begin
                if (commit_valid) begin
                    entry_d = entry_inc;
                    if (mis_mask != 4'b0000) begin
                        if (err_q == '0) begin
                            ferr_idx_d  = entry_q[IDX_W-1:0];
                            ferr_mask_d = mis_mask;
                        end
                        if (err_q != {ERR_W{1'b1}}) begin
                            err_d = err_q + ERR_W'(1);
                        end
                    end
                    if ((entry_inc == num_q) ||
                        ((mis_mask != 4'b0000) && (STOP_ON_ERR != 0))) begin
                        state_d = StDone;
                    end
                end else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            num_q       <= '0;
            entry_q     <= '0;
            err_q       <= '0;
            ferr_idx_q  <= '0;
            ferr_mask_q <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            entry_q     <= entry_d;
            err_q       <= err_d;
            ferr_idx_q  <= ferr_idx_d;
            ferr_mask_q <= ferr_mask_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy           = (state_q == StRun);
    assign done           = (state_q == StDone);
    assign pass           = done && (err_q == '0) && !overrun_q && !timeout_q;
    assign err_count      = err_q;
    assign first_err_idx  = ferr_idx_q;
    assign first_err_mask = ferr_mask_q;
    assign entry_idx      = entry_q;
    assign overrun        = overrun_q;
    assign timeout        = timeout_q;

endmodule
